// File: rtl/wave_sequencer.sv
// Wave-ROM address sequencer: steps sig_addr through [lo_addr, hi_addr] in up, down or ping-pong order.
// Ping-pong order (mode 10) is built only when WAVE_SEQ_PINGPONG_EN is defined; otherwise mode 10 runs as up.
//
// state | meaning
// IDLE  | waiting for en; sig_addr parked, busy=0
// RUN   | one address step per enabled clock, busy=1
// DONE  | one-shot period finished; outputs frozen until restart
module wave_sequencer #(
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk_freq2,
   input  logic              rst_n_key0,
   input  logic              en,
   input  logic              restart,
   input  logic [1:0]        mode,
   input  logic              one_shot,
   input  logic [ADDR_W-1:0] lo_addr,
   input  logic [ADDR_W-1:0] hi_addr,
   output logic [ADDR_W-1:0] sig_addr,
   output logic              wrap,
   output logic              busy,
   output logic [CNT_W-1:0]  loop_cnt
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_d;
   logic [ADDR_W-1:0] hi_eff;
   logic [ADDR_W-1:0] first_addr;
   logic [CNT_W-1:0]  cnt_d;
   logic              wrap_d;
   logic              busy_d;
   logic              in_range;
   logic              mode_down;
   logic              period_end;
   logic              pp_step;
   logic              dir_cur;
   logic              dir_d;

   // An inverted range collapses to the single address lo_addr.
   assign hi_eff     = (lo_addr > hi_addr) ? lo_addr : hi_addr;
   assign mode_down  = (mode == 2'b01);
   assign first_addr = mode_down ? hi_eff : lo_addr;
   assign in_range   = (sig_addr >= lo_addr) && (sig_addr <= hi_eff);

`ifdef WAVE_SEQ_PINGPONG_EN
   logic dir_q;

   always_ff @(posedge clk_freq2 or negedge rst_n_key0) begin
      if (!rst_n_key0) begin
         dir_q <= 1'b0;
      end else begin
         dir_q <= dir_d;
      end
   end

   assign dir_cur = dir_q;
`else
   // Without ping-pong the direction has no storage; it is always ascending.
   logic unused_dir;

   assign dir_cur    = 1'b0;
   assign unused_dir = dir_d;
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = sig_addr;
      wrap_d     = 1'b0;
      busy_d     = busy;
      cnt_d      = loop_cnt;
      dir_d      = dir_cur;
      period_end = 1'b0;
      pp_step    = 1'b0;
      if (restart) begin
         state_d = IDLE;
         addr_d  = lo_addr;
         busy_d  = 1'b0;
         cnt_d   = '0;
         dir_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (en) begin
                  state_d = RUN;
                  addr_d  = first_addr;
                  busy_d  = 1'b1;
                  dir_d   = 1'b0;
               end
            end
            RUN: begin
               if (en) begin
                  if (!in_range) begin
                     addr_d = first_addr;
                     dir_d  = 1'b0;
                  end else if (lo_addr == hi_eff) begin
                     period_end = 1'b1;
`ifdef WAVE_SEQ_PINGPONG_EN
                  end else if (mode == 2'b10) begin
                     pp_step = 1'b1;
                     if (dir_cur ? (sig_addr == lo_addr) : (sig_addr != hi_eff)) begin
                        addr_d = sig_addr + ADDR_ONE;
                        dir_d  = 1'b0;
                     end else begin
                        addr_d = sig_addr - ADDR_ONE;
                        dir_d  = 1'b1;
                        if (addr_d == lo_addr) begin
                           period_end = 1'b1;
                           dir_d      = 1'b0;
                        end
                     end
`endif
                  end else if (mode_down) begin
                     if (sig_addr == lo_addr) begin
                        addr_d     = hi_eff;
                        period_end = 1'b1;
                        dir_d      = 1'b0;
                     end else begin
                        addr_d = sig_addr - ADDR_ONE;
                     end
                  end else begin
                     if (sig_addr == hi_eff) begin
                        addr_d     = lo_addr;
                        period_end = 1'b1;
                        dir_d      = 1'b0;
                     end else begin
                        addr_d = sig_addr + ADDR_ONE;
                     end
                  end
                  if (period_end) begin
                     wrap_d = 1'b1;
                     if (loop_cnt != CNT_MAX) begin
                        cnt_d = loop_cnt + CNT_ONE;
                     end
                     // One-shot up/down stop on the end address; ping-pong stops where it lands (lo_addr).
                     if (one_shot) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        if (!pp_step) begin
                           addr_d = sig_addr;
                        end
                     end
                  end
               end
            end
            DONE: begin
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_freq2 or negedge rst_n_key0) begin
      if (!rst_n_key0) begin
         state_q  <= IDLE;
         sig_addr <= '0;
         wrap     <= 1'b0;
         busy     <= 1'b0;
         loop_cnt <= '0;
      end else begin
         state_q  <= state_d;
         sig_addr <= addr_d;
         wrap     <= wrap_d;
         busy     <= busy_d;
         loop_cnt <= cnt_d;
      end
   end

endmodule
